raster_to_block: RTL and testbench



---
 rtl/jpeg_pkg.sv | 15 +
 rtl/raster_to_block_band_ram.sv | 38 +++
 rtl/raster_to_block.sv | 151 +++++++++++++++
 tb/tb_raster_to_block.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_pkg.sv
// Shared types for the FDCT front end: pixels, 8-pixel block rows, byte-lane helper.
package jpeg_pkg;

  localparam int BLK_N = 8;
  localparam int LANE_W = $clog2(BLK_N);

  typedef logic [7:0] pixel_t;
  typedef pixel_t [BLK_N-1:0] blk_row_t;

  // One-hot byte-lane enable for a column position within a block row.
  function automatic logic [BLK_N-1:0] lane_mask(input logic [LANE_W-1:0] lane);
    return BLK_N'(1) << lane;
  endfunction

endpackage

// File: rtl/raster_to_block_band_ram.sv
// Simple dual-port band store: byte-enabled write port, registered read port with enable.
module band_ram
  import jpeg_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [BLK_N-1:0]  wr_be,
  input  blk_row_t          wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output blk_row_t          rd_data
);

  blk_row_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < BLK_N; i++) begin
        if (wr_be[i]) mem[wr_addr][i] <= wr_data[i];
      end
    end
  end

  // Read data only moves on an enabled read, so it doubles as the held output row.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/raster_to_block.sv
// Raster-to-block converter: ping-pong 8-line band store, re-emitted as 8x8 block rows.
module raster_to_block
  import jpeg_pkg::*;
#(
  parameter int IMG_WIDTH = 640
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [7:0] pix_in,
  input  logic       pix_valid,
  output logic       pix_ready,
  output logic [7:0] dout [BLK_N-1:0],
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       dout_last
);

  localparam int BLKS       = IMG_WIDTH / BLK_N;
  localparam int BANK_WORDS = BLK_N * BLKS;
  localparam int DEPTH      = 2 * BANK_WORDS;
  localparam int ADDR_W     = $clog2(DEPTH);
  localparam int COL_W      = $clog2(IMG_WIDTH);
  localparam int BLK_W      = (BLKS > 1) ? $clog2(BLKS) : 1;

  localparam logic [COL_W-1:0]  COL_MAX = COL_W'(IMG_WIDTH - 1);
  localparam logic [BLK_W-1:0]  BLK_MAX = BLK_W'(BLKS - 1);
  localparam logic [LANE_W-1:0] ROW_MAX = LANE_W'(BLK_N - 1);

  if (IMG_WIDTH < BLK_N || (IMG_WIDTH % BLK_N) != 0) begin : g_width_check
    $error("raster_to_block: IMG_WIDTH must be a multiple of 8 and at least 8");
  end

  logic [COL_W-1:0]  col;
  logic [LANE_W-1:0] line;
  logic              wbank;
  logic [BLK_W-1:0]  blk;
  logic [LANE_W-1:0] row;
  logic              rbank;
  logic [1:0]        full;
  logic [1:0]        full_nxt;

  logic              wr_fire;
  logic              wr_band_end;
  logic              advance;
  logic              rd_fire;
  logic              rd_band_end;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [BLK_N-1:0]  wr_be;
  blk_row_t          wr_data;
  blk_row_t          rd_data;

  assign pix_ready   = !full[wbank];
  assign wr_fire     = pix_valid && pix_ready;
  assign wr_band_end = wr_fire && (col == COL_MAX) && (line == ROW_MAX);

  assign advance     = !dout_valid || dout_ready;
  assign rd_fire     = advance && full[rbank];
  assign rd_band_end = rd_fire && (blk == BLK_MAX) && (row == ROW_MAX);

  assign wr_addr = ADDR_W'(int'(wbank) * BANK_WORDS + int'(line) * BLKS + int'(col >> LANE_W));
  assign rd_addr = ADDR_W'(int'(rbank) * BANK_WORDS + int'(row) * BLKS + int'(blk));
  assign wr_be   = lane_mask(col[LANE_W-1:0]);
  assign wr_data = {BLK_N{pix_in}};

  // Banks never alias, so a fill of one and a release of the other can land together.
  always_comb begin
    full_nxt = full;
    if (wr_band_end) full_nxt[wbank] = 1'b1;
    if (rd_band_end) full_nxt[rbank] = 1'b0;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      full <= '0;
    end else begin
      full <= full_nxt;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      col   <= '0;
      line  <= '0;
      wbank <= 1'b0;
    end else if (wr_fire) begin
      if (col == COL_MAX) begin
        col <= '0;
        if (line == ROW_MAX) begin
          line  <= '0;
          wbank <= ~wbank;
        end else begin
          line <= line + LANE_W'(1);
        end
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // Row steps first so each block's eight rows leave before moving right.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      blk   <= '0;
      row   <= '0;
      rbank <= 1'b0;
    end else if (rd_fire) begin
      if (row == ROW_MAX) begin
        row <= '0;
        if (blk == BLK_MAX) begin
          blk   <= '0;
          rbank <= ~rbank;
        end else begin
          blk <= blk + BLK_W'(1);
        end
      end else begin
        row <= row + LANE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
    end else if (advance) begin
      dout_valid <= full[rbank];
      dout_last  <= rd_band_end;
    end
  end

  band_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_band_ram (
    .clk     (clk),
    .nrst    (nrst),
    .wr_en   (wr_fire),
    .wr_addr (wr_addr),
    .wr_be   (wr_be),
    .wr_data (wr_data),
    .rd_en   (rd_fire),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_comb begin
    for (int i = 0; i < BLK_N; i++) dout[i] = rd_data[i];
  end

endmodule

// File: tb/tb_raster_to_block.sv
// Bench for raster_to_block at IMG_WIDTH=16: band scoreboard plus directed literal checks.
module tb_raster_to_block;

  localparam int W        = 16;
  localparam int BAND_PIX = W * 8;
  localparam int BEATS    = W;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic [7:0] pix_in = '0;
  logic       pix_valid = 1'b0;
  logic       pix_ready;
  logic [7:0] dout [7:0];
  logic       dout_valid;
  logic       dout_ready = 1'b0;
  logic       dout_last;

  raster_to_block #(.IMG_WIDTH(W)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [7:0]  band_buf [BAND_PIX];
  int          band_cnt = 0;
  int          band_done_cyc = -1;
  logic [64:0] exp_q [$];
  logic [63:0] rcv_data [$];
  logic        rcv_last [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] dout_word();
    logic [63:0] d;
    for (int i = 0; i < 8; i++) d[8*i +: 8] = dout[i];
    return d;
  endfunction

  // Model: collect a band in raster order, then emit its beats in block order.
  always @(negedge clk) begin : monitor
    logic [63:0] d;
    logic [64:0] e;
    logic        prev_stall;
    logic [63:0] prev_d;
    logic        prev_l;
    d = dout_word();
    if (!nrst) begin
      band_cnt = 0;
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 64'(dout_valid), 64'd1);
        check("stall_data", d, prev_d);
        check("stall_last", 64'(dout_last), 64'(prev_l));
      end
      if (pix_valid && pix_ready) begin
        band_buf[band_cnt] = pix_in;
        band_cnt++;
        if (band_cnt == BAND_PIX) begin
          for (int k = 0; k < BEATS; k++) begin
            for (int i = 0; i < 8; i++) e[8*i +: 8] = band_buf[(k % 8) * W + 8 * (k / 8) + i];
            e[64] = (k == BEATS - 1);
            exp_q.push_back(e);
          end
          band_cnt = 0;
          band_done_cyc = cyc;
        end
      end
      if (dout_valid && dout_ready) begin
        rcv_data.push_back(d);
        rcv_last.push_back(dout_last);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat_unexpected: got %h expected no beat", d);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", d, e[63:0]);
          check("beat_last", 64'(dout_last), 64'(e[64]));
        end
      end
      prev_stall = dout_valid && !dout_ready;
      prev_d = d;
      prev_l = dout_last;
    end
  end

  task automatic do_reset();
    nrst = 1'b0;
    pix_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    rcv_data.delete();
    rcv_last.delete();
  endtask

  task automatic send_pixels(input int start, input int n, input int gap_pct, input int offset);
    int g = start;
    int budget = 0;
    logic acc;
    while (g < start + n) begin
      pix_valid = ($urandom_range(99) >= gap_pct);
      pix_in = 8'((g + offset) % 256);
      @(negedge clk);
      acc = pix_valid && pix_ready;
      @(posedge clk);
      #1;
      if (acc) g++;
      budget++;
      if (budget > 20000) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: got %0d accepts expected %0d", g - start, n);
        break;
      end
    end
    pix_valid = 1'b0;
  endtask

  task automatic wait_drain(input int n, input string tag);
    int t = 0;
    while (rcv_data.size() < n && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_count"}, 64'(rcv_data.size()), 64'(n));
    check({tag, "_leftover"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin : stim
    int first_cyc;
    int ready_low;
    int acc;
    logic sending;
    logic done;
    logic found;
    logic prev_pr;
    logic [15:0] lv;

    // Test 1: single band, free-flowing output
    do_reset();
    check("rst_valid", 64'(dout_valid), 64'd0);
    check("rst_last", 64'(dout_last), 64'd0);
    check("rst_ready", 64'(pix_ready), 64'd1);
    check("rst_dout", dout_word(), 64'd0);
    dout_ready = 1'b1;
    send_pixels(0, BAND_PIX, 0, 0);
    first_cyc = -1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (dout_valid) begin
        first_cyc = cyc;
        break;
      end
    end
    check("t1_latency", 64'(first_cyc), 64'(band_done_cyc + 2));
    wait_drain(16, "t1");
    check("t1_beat0", rcv_data[0], 64'h0706050403020100);
    check("t1_beat8", rcv_data[8], 64'h0F0E0D0C0B0A0908);
    check("t1_beat9", rcv_data[9], 64'h1F1E1D1C1B1A1918);
    lv = '0;
    for (int k = 0; k < 16; k++) lv[k] = (k < rcv_last.size()) ? rcv_last[k] : 1'b0;
    check("t1_last", 64'(lv), 64'h8000);

    // Test 2: three back-to-back bands, input never throttled
    do_reset();
    dout_ready = 1'b1;
    ready_low = 0;
    sending = 1'b1;
    fork
      begin
        send_pixels(0, 3 * BAND_PIX, 0, 0);
        sending = 1'b0;
      end
      begin
        while (sending) begin
          @(negedge clk);
          if (!pix_ready) ready_low++;
        end
      end
    join
    check("t2_ready_low", 64'(ready_low), 64'd0);
    wait_drain(48, "t2");
    check("t2_band1_beat0", rcv_data[16], 64'h8786858483828180);
    check("t2_band2_beat0", rcv_data[32], 64'h0706050403020100);

    // Test 3: output blocked from reset, both banks fill
    do_reset();
    dout_ready = 1'b0;
    acc = 0;
    pix_valid = 1'b1;
    for (int n = 0; n < 400; n++) begin
      pix_in = 8'(acc);
      @(negedge clk);
      if (!pix_ready) break;
      acc++;
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1 pix_valid = 1'b0;
    check("t3_accepts", 64'(acc), 64'd256);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("t3_hold_valid", 64'(dout_valid), 64'd1);
    check("t3_hold_data", dout_word(), 64'h0706050403020100);
    check("t3_hold_ready", 64'(pix_ready), 64'd0);
    prev_pr = pix_ready;
    @(posedge clk);
    #1 dout_ready = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (dout_valid && dout_last) begin
        check("t3_ready_after", 64'(pix_ready), 64'd1);
        check("t3_ready_before", 64'(prev_pr), 64'd0);
        found = 1'b1;
        break;
      end
      prev_pr = pix_ready;
    end
    check("t3_last_seen", 64'(found), 64'd1);
    wait_drain(32, "t3");

    // Test 4: random input gaps and output stalls over four bands
    do_reset();
    done = 1'b0;
    fork
      begin
        send_pixels(0, 4 * BAND_PIX, 50, 0);
        done = 1'b1;
      end
      begin
        while (!done) begin
          dout_ready = ($urandom_range(99) < 70);
          @(posedge clk);
          #1;
        end
        dout_ready = 1'b1;
      end
    join
    wait_drain(64, "t4");

    // Test 5: asynchronous reset partway into a band with output stalled
    do_reset();
    dout_ready = 1'b0;
    send_pixels(0, BAND_PIX + 70, 0, 0);
    @(negedge clk);
    check("t5_pre_valid", 64'(dout_valid), 64'd1);
    @(posedge clk);
    #3 nrst = 1'b0;
    #1;
    check("t5_rst_valid", 64'(dout_valid), 64'd0);
    check("t5_rst_ready", 64'(pix_ready), 64'd1);
    check("t5_rst_last", 64'(dout_last), 64'd0);
    @(posedge clk);
    #1 nrst = 1'b1;
    rcv_data.delete();
    rcv_last.delete();
    dout_ready = 1'b1;
    send_pixels(0, BAND_PIX, 0, 77);
    wait_drain(16, "t5");
    check("t5_beat0", rcv_data[0], 64'h54535251504F4E4D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
